// File: rtl/fetch_unit.sv
// Credit-limited instruction fetch unit: issues PC-stage addresses to instruction memory,
// tracks in-flight requests, buffers in-order responses for decode, and discards stale data after a flush.
module fetch_unit #(
    parameter int unsigned BUFFER_DEPTH = 2,
    parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] address_i,
    input  logic        address_valid_i,
    output logic        address_taken_o,
    output logic        mem_request_o,
    output logic [31:0] mem_address_o,
    input  logic        mem_grant_i,
    input  logic        mem_response_valid_i,
    input  logic [31:0] mem_data_i,
    input  logic        flush_i,
    output logic [31:0] instruction_o,
    output logic [31:0] instruction_address_o,
    output logic        instruction_valid_o,
    input  logic        decode_ready_i
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      buf_data_q  [BUFFER_DEPTH];
    logic [31:0]      buf_addr_q  [BUFFER_DEPTH];
    logic [31:0]      infl_addr_q [BUFFER_DEPTH];

    logic [PTR_W-1:0] buf_head_q, buf_head_d;
    logic [PTR_W-1:0] buf_tail_q, buf_tail_d;
    logic [PTR_W-1:0] infl_head_q, infl_head_d;
    logic [PTR_W-1:0] infl_tail_q, infl_tail_d;
    logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0] infl_cnt_q, infl_cnt_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;

    logic [CNT_W:0]   credit;
    logic             permitted;
    logic             issue;
    logic             resp_live;
    logic             resp_drop;
    logic             consume;

    // Handshakes: a memory request transfers when mem_request_o && mem_grant_i in the same
    // cycle; a buffered instruction transfers when instruction_valid_o && decode_ready_i.
    // Responses carry no ready and must be absorbed on arrival, which the credit limit guarantees.
    always_comb begin
        credit    = {1'b0, buf_cnt_q} + {1'b0, infl_cnt_q} + {1'b0, disc_cnt_q};
        permitted = credit < (CNT_W+1)'(BUFFER_DEPTH);
    end

    assign mem_request_o   = address_valid_i && permitted && !flush_i && !reset_i;
    assign mem_address_o   = address_i;
    assign issue           = mem_request_o && mem_grant_i;
    assign address_taken_o = issue;

    // Stray responses with nothing outstanding (e.g. after reset) fall through both terms.
    assign resp_drop = mem_response_valid_i && (disc_cnt_q != '0);
    assign resp_live = mem_response_valid_i && (disc_cnt_q == '0) && (infl_cnt_q != '0);
    assign consume   = instruction_valid_o && decode_ready_i;

    assign instruction_valid_o   = (buf_cnt_q != '0);
    assign instruction_o         = instruction_valid_o ? buf_data_q[buf_head_q] : NOP_WORD;
    assign instruction_address_o = instruction_valid_o ? buf_addr_q[buf_head_q] : 32'h00000000;

    always_comb begin
        buf_head_d  = buf_head_q;
        buf_tail_d  = buf_tail_q;
        infl_head_d = infl_head_q;
        infl_tail_d = infl_tail_q;
        buf_cnt_d   = buf_cnt_q;
        infl_cnt_d  = infl_cnt_q;
        disc_cnt_d  = disc_cnt_q;
        if (flush_i) begin
            // Everything still owed by memory becomes discard debt; a response landing now pays one.
            buf_head_d  = '0;
            buf_tail_d  = '0;
            infl_head_d = '0;
            infl_tail_d = '0;
            buf_cnt_d   = '0;
            infl_cnt_d  = '0;
            disc_cnt_d  = disc_cnt_q + infl_cnt_q - CNT_W'(resp_drop) - CNT_W'(resp_live);
        end else begin
            if (resp_drop) begin
                disc_cnt_d = disc_cnt_q - 1'b1;
            end
            if (resp_live) begin
                infl_head_d = infl_head_q + 1'b1;
                buf_tail_d  = buf_tail_q + 1'b1;
            end
            if (consume) begin
                buf_head_d = buf_head_q + 1'b1;
            end
            if (issue) begin
                infl_tail_d = infl_tail_q + 1'b1;
            end
            infl_cnt_d = infl_cnt_q + CNT_W'(issue) - CNT_W'(resp_live);
            buf_cnt_d  = buf_cnt_q + CNT_W'(resp_live) - CNT_W'(consume);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            buf_head_q  <= '0;
            buf_tail_q  <= '0;
            infl_head_q <= '0;
            infl_tail_q <= '0;
            buf_cnt_q   <= '0;
            infl_cnt_q  <= '0;
            disc_cnt_q  <= '0;
        end else begin
            buf_head_q  <= buf_head_d;
            buf_tail_q  <= buf_tail_d;
            infl_head_q <= infl_head_d;
            infl_tail_q <= infl_tail_d;
            buf_cnt_q   <= buf_cnt_d;
            infl_cnt_q  <= infl_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
        end
    end

    // Storage needs no reset: the counts alone decide what is visible.
    always_ff @(posedge clock_i) begin
        if (!flush_i && resp_live) begin
            buf_data_q[buf_tail_q] <= mem_data_i;
            buf_addr_q[buf_tail_q] <= infl_addr_q[infl_head_q];
        end
        if (issue) begin
            infl_addr_q[infl_tail_q] <= address_i;
        end
    end

endmodule
